clkdiv_monitor: RTL and testbench



---
 rtl/clkdiv_monitor_if.sv | 17 +
 rtl/clkdiv_monitor.sv | 99 +++++++++
 tb/tb_clkdiv_monitor.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/clkdiv_monitor_if.sv
// clkdiv_monitor_if: control inputs and measurement outputs of clkdiv_monitor.
interface clkdiv_monitor_if #(parameter int PW = 8, parameter int CW = 16);
    logic          en;
    logic          clr;
    logic          clkdiv_in;
    logic          rise_tick;
    logic          fall_tick;
    logic [PW-1:0] period;
    logic          period_vld;
    logic          lock;
    logic          err;
    logic [CW-1:0] edge_cnt;
    modport master (output en, clr, clkdiv_in,
                    input rise_tick, fall_tick, period, period_vld, lock, err, edge_cnt);
    modport slave  (input en, clr, clkdiv_in,
                    output rise_tick, fall_tick, period, period_vld, lock, err, edge_cnt);
endinterface

// File: rtl/clkdiv_monitor.sv
// clkdiv_monitor: samples a divided clock, emits edge ticks, measures its period and tracks lock/error.
// Define CLKDIV_MON_SYNC2_EN to put a 2-flop synchronizer in front of the sampler.
module clkdiv_monitor #(
    parameter int EXP_PERIOD = 8,
    parameter int PW         = 8,
    parameter int CW         = 16,
    parameter int LOCK_CNT   = 4,
    parameter int TIMEOUT    = 32
) (
    input logic             clk,
    input logic             rst_n,
    clkdiv_monitor_if.slave bus
);
    localparam int MW = $clog2(LOCK_CNT + 1);
    typedef enum logic [1:0] {IDLE, SYNC, MEAS, LOCKED} state_t;
    state_t        state_q, state_d;
    logic          s_q, prev_q;
    logic          rise_tick_q, rise_tick_d, fall_tick_q, fall_tick_d;
    logic          period_vld_q, period_vld_d, lock_q, lock_d, err_q, err_d;
    logic [PW-1:0] pcnt_q, pcnt_d, period_q, period_d;
    logic [CW-1:0] edge_cnt_q, edge_cnt_d;
    logic [MW-1:0] match_q, match_d;
    logic          samp, act, meas, rise_evt, fall_evt, hit, tmo;
`ifdef CLKDIV_MON_SYNC2_EN
    logic [1:0] sync_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sync_q <= '0;
        else sync_q <= {sync_q[0], bus.clkdiv_in};
    assign samp = sync_q[1];
`else
    assign samp = bus.clkdiv_in;
`endif
    assign act      = bus.en && state_q != IDLE;
    assign meas     = act && state_q != SYNC;
    assign rise_evt = s_q & ~prev_q;
    assign fall_evt = ~s_q & prev_q;
    assign hit      = pcnt_q == PW'(EXP_PERIOD);
    // a rise on the timeout cycle is a (mismatching) period, not a stall
    assign tmo      = !rise_evt && pcnt_q == PW'(TIMEOUT);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q      <= IDLE;
            s_q          <= 1'b0;
            prev_q       <= 1'b0;
            rise_tick_q  <= 1'b0;
            fall_tick_q  <= 1'b0;
            period_vld_q <= 1'b0;
            lock_q       <= 1'b0;
            err_q        <= 1'b0;
            pcnt_q       <= '0;
            period_q     <= '0;
            edge_cnt_q   <= '0;
            match_q      <= '0;
        end else begin
            state_q      <= state_d;
            s_q          <= samp;
            prev_q       <= s_q;
            rise_tick_q  <= rise_tick_d;
            fall_tick_q  <= fall_tick_d;
            period_vld_q <= period_vld_d;
            lock_q       <= lock_d;
            err_q        <= err_d;
            pcnt_q       <= pcnt_d;
            period_q     <= period_d;
            edge_cnt_q   <= edge_cnt_d;
            match_q      <= match_d;
        end
    always_comb begin
        state_d = state_q;
        if (!bus.en) state_d = IDLE;
        else
            case (state_q)
                IDLE:    state_d = SYNC;
                SYNC:    state_d = rise_evt ? MEAS : SYNC;
                MEAS:    state_d = tmo ? SYNC
                                 : (rise_evt && hit && match_q == MW'(LOCK_CNT - 1)) ? LOCKED : MEAS;
                default: state_d = tmo ? SYNC : (rise_evt && !hit) ? MEAS : LOCKED;
            endcase
    end
    always_comb begin
        rise_tick_d  = act && rise_evt;
        fall_tick_d  = act && fall_evt;
        period_vld_d = meas && rise_evt;
        period_d     = period_vld_d ? pcnt_q : period_q;
        pcnt_d       = !act ? '0 : rise_evt ? PW'(1) : tmo ? '0 : pcnt_q + PW'(pcnt_q != '1);
        match_d      = (!act || tmo || (period_vld_d && !hit)) ? '0
                     : (period_vld_d && state_q == MEAS) ? match_q + MW'(1) : match_q;
        lock_d       = state_d == LOCKED;
        err_d        = (act && tmo) || (period_vld_d && !hit) || (err_q && !bus.clr);
        edge_cnt_d   = (bus.clr ? '0 : edge_cnt_q) + CW'(act && rise_evt);
    end
    assign bus.rise_tick  = rise_tick_q;
    assign bus.fall_tick  = fall_tick_q;
    assign bus.period     = period_q;
    assign bus.period_vld = period_vld_q;
    assign bus.lock       = lock_q;
    assign bus.err        = err_q;
    assign bus.edge_cnt   = edge_cnt_q;
endmodule

// File: tb/tb_clkdiv_monitor.sv
// tb_clkdiv_monitor: random divided-clock waveforms checked cycle by cycle against a behavioural model.
module tb_clkdiv_monitor;
    localparam int EXP   = 8;
    localparam int TMO   = 32;
    localparam int LOCKN = 4;
    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_fail = 0;
    int   mode, since, good, e_period, e_edges;
    bit   e_rise, e_fall, e_vld, e_lock, e_err;
    logic [1:0] sh;
    int   r, per, hi, ci;
    clkdiv_monitor_if #(.PW(8), .CW(16)) bus ();
    clkdiv_monitor dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask
    task automatic model_reset();
        mode = 0; since = 0; good = 0; e_period = 0; e_edges = 0;
        e_rise = 0; e_fall = 0; e_vld = 0; e_lock = 0; e_err = 0; sh = '0;
    endtask
    task automatic model_step();
        bit rise, fall, act, bad, tmo;
        if (!rst_n) model_reset();
        else begin
            rise   = sh[0] && !sh[1];
            fall   = !sh[0] && sh[1];
            act    = bus.en && mode != 0;
            e_rise = act && rise;
            e_fall = act && fall;
            e_vld  = act && mode >= 2 && rise;
            bad    = e_vld && since != EXP;
            tmo    = act && !rise && since == TMO;
            if (e_vld) e_period = since;
            e_err   = bad || tmo || (e_err && !bus.clr);
            e_edges = ((bus.clr ? 0 : e_edges) + int'(act && rise)) & 16'hFFFF;
            if (!bus.en) begin mode = 0; since = 0; good = 0; end
            else if (mode == 0) mode = 1;
            else if (rise) begin
                if (mode == 1) mode = 2;
                else if (bad) begin mode = 2; good = 0; end
                else if (mode == 2) begin good++; if (good == LOCKN) mode = 3; end
                since = 1;
            end else if (tmo) begin mode = 1; good = 0; since = 0; end
            else since = (since < 255) ? since + 1 : 255;
            e_lock = mode == 3;
            sh = {sh[0], bus.clkdiv_in};
        end
    endtask
    task automatic compare_all();
        chk("rise_tick", bus.rise_tick, e_rise);
        chk("fall_tick", bus.fall_tick, e_fall);
        chk("period", bus.period, e_period);
        chk("period_vld", bus.period_vld, e_vld);
        chk("lock", bus.lock, e_lock);
        chk("err", bus.err, e_err);
        chk("edge_cnt", bus.edge_cnt, e_edges);
    endtask
    task automatic tick(input bit c);
        bus.clr = c;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask
    task automatic wave(input int n, input int h, input int l, input int c);
        for (int p = 0; p < n; p++)
            for (int i = 0; i < h + l; i++) begin
                bus.clkdiv_in = i < h;
                tick(p * (h + l) + i == c);
            end
    endtask
    initial begin
        rst_n = 1'b0; bus.en = 1'b0; bus.clr = 1'b0; bus.clkdiv_in = 1'b0;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            bus.clkdiv_in = ~bus.clkdiv_in;
            tick(0);
        end
        #5 rst_n = 1'b1;
        bus.clkdiv_in = 1'b0;
        tick(0);
        bus.en = 1'b1;
        wave(8, 4, 4, -1);
        chk("ideal_lock", bus.lock, 1);
        chk("ideal_period", bus.period, 8);
        chk("ideal_err", bus.err, 0);
        wave(1, 4, 5, -1);
        wave(6, 4, 4, -1);
        chk("relock_after_9", bus.lock, 1);
        chk("err_sticky", bus.err, 1);
        wave(1, 4, 5, -1);
        wave(6, 4, 4, 1);
        chk("clr_vs_set", bus.err, 1);
        wave(6, 4, 4, 5);
        chk("clr_alone", bus.err, 0);
        bus.clkdiv_in = 1'b0;
        for (int i = 0; i < 40; i++) tick(0);
        chk("stall_lock", bus.lock, 0);
        chk("stall_err", bus.err, 1);
        wave(7, 4, 4, -1);
        chk("stall_relock", bus.lock, 1);
        wave(1, 2, 6, -1);
        bus.en = 1'b0;
        wave(3, 4, 4, -1);
        chk("en_off_lock", bus.lock, 0);
        chk("en_off_period", bus.period, 8);
        chk("en_off_edges", bus.edge_cnt, e_edges);
        bus.en = 1'b1;
        wave(7, 4, 4, -1);
        chk("en_on_relock", bus.lock, 1);
        for (int p = 0; p < 250; p++) begin
            r = $urandom_range(0, 99);
            per = (r < 70) ? 8 : (r < 90) ? $urandom_range(2, 14) : $urandom_range(30, 45);
            hi = $urandom_range(1, per - 1);
            ci = ($urandom_range(0, 7) == 0) ? $urandom_range(0, per - 1) : -1;
            bus.en = $urandom_range(0, 39) != 0;
            wave(1, hi, per - hi, ci);
        end
        bus.en = 1'b1;
        wave(8, 3, 5, -1);
        chk("random_relock", bus.lock, 1);
        wave(1, 4, 2, -1);
        #2 rst_n = 1'b0;
        #1 model_reset();
        compare_all();
        chk("async_rst_edges", bus.edge_cnt, 0);
        tick(0);
        tick(0);
        rst_n = 1'b1;
        wave(8, 4, 4, -1);
        chk("post_rst_lock", bus.lock, 1);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
